// File: rtl/sram_pkg.sv
// Shared SRAM definitions: default widths, command record and arbitration grant codes.
package sram_pkg;

   localparam int SRAM_ADDR_W = 18;
   localparam int SRAM_DATA_W = 32;

   typedef struct packed {
      logic                   we;
      logic [SRAM_ADDR_W-1:0] addr;
      logic [SRAM_DATA_W-1:0] wdata;
   } sram_cmd_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_RD,
      GNT_WR
   } sram_gnt_t;

   // Bits needed to hold a count from 0 up to and including max_val.
   function automatic int cnt_width(input int max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Command/response channel between the port arbiter (master) and one sram_controller (slave).
interface sram_port_arbiter_if #(
   parameter int ADDR_W = sram_pkg::SRAM_ADDR_W,
   parameter int DATA_W = sram_pkg::SRAM_DATA_W
);
   logic              m_valid;
   logic              m_ready;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_rsp_valid;
   logic [DATA_W-1:0] m_rsp_data;

   modport master (
      output m_valid, m_we, m_addr, m_wdata,
      input  m_ready, m_rsp_valid, m_rsp_data
   );

   modport slave (
      input  m_valid, m_we, m_addr, m_wdata,
      output m_ready, m_rsp_valid, m_rsp_data
   );
endinterface

// File: rtl/sram_rd_tracker.sv
// Tracks read commands in flight to the controller and registers the in-order read return.
module sram_rd_tracker
   import sram_pkg::*;
#(
   parameter int DATA_W          = SRAM_DATA_W,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fire_rd,
   input  logic              pending_rd,
   input  logic              rsp_valid,
   input  logic [DATA_W-1:0] rsp_data,
   output logic              rd_full,
   output logic              active_nxt,
   output logic              rd_rsp_valid,
   output logic [DATA_W-1:0] rd_rsp_data
);

   localparam int CNT_W = cnt_width(MAX_OUTSTANDING);
   localparam logic [CNT_W:0] MAX_CNT = (CNT_W + 1)'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] out_nxt;
   logic             dec;

   // A response with nothing in flight is stray (e.g. from before a reset) and must not underflow.
   assign dec = rsp_valid && (outstanding != '0);

   always_comb begin
      out_nxt = outstanding;
      if (fire_rd && !dec) begin
         out_nxt = outstanding + 1'b1;
      end else if (!fire_rd && dec) begin
         out_nxt = outstanding - 1'b1;
      end
   end

   assign rd_full    = ({1'b0, outstanding} + {{CNT_W{1'b0}}, pending_rd}) >= MAX_CNT;
   assign active_nxt = (out_nxt != '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         outstanding  <= '0;
         rd_rsp_valid <= 1'b0;
         rd_rsp_data  <= '0;
      end else begin
         outstanding  <= out_nxt;
         rd_rsp_valid <= rsp_valid;
         rd_rsp_data  <= rsp_data;
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Read-priority arbiter sharing one SRAM controller port between a reader and a writer.
// Optional statistics counters are enabled by defining SRAM_ARB_STATS_EN.
module sram_port_arbiter
   import sram_pkg::*;
#(
   parameter int ADDR_W          = SRAM_ADDR_W,
   parameter int DATA_W          = SRAM_DATA_W,
   parameter int MAX_RD_STREAK   = 8,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_rsp_valid,
   output logic [DATA_W-1:0] rd_rsp_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   sram_port_arbiter_if.master m,
   output logic              busy
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [31:0]       stat_rd_cnt,
   output logic [31:0]       stat_wr_cnt,
   output logic [15:0]       stat_starve_cnt
`endif
);

   localparam logic [7:0] STREAK_MAX = 8'(MAX_RD_STREAK);

   logic      load_ok;
   logic      rd_full;
   logic      rd_elig;
   logic      streak_sat;
   logic      fire_rd;
   logic      pending_rd;
   logic      active_nxt;
   logic      m_valid_nxt;
   logic [7:0] streak;
   sram_gnt_t gnt;

   assign load_ok    = !m.m_valid || m.m_ready;
   assign rd_elig    = rd_valid && !rd_full;
   assign streak_sat = (streak == STREAK_MAX);

   // Reads win unless the writer has waited out a full read streak.
   always_comb begin
      gnt = GNT_NONE;
      if (load_ok) begin
         if (wr_valid && (!rd_elig || streak_sat)) begin
            gnt = GNT_WR;
         end else if (rd_elig) begin
            gnt = GNT_RD;
         end
      end
   end

   assign rd_ready    = (gnt == GNT_RD);
   assign wr_ready    = (gnt == GNT_WR);
   assign fire_rd     = m.m_valid && m.m_ready && !m.m_we;
   assign pending_rd  = m.m_valid && !m.m_we;
   assign m_valid_nxt = load_ok ? (gnt != GNT_NONE) : m.m_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m.m_valid <= 1'b0;
         m.m_we    <= 1'b0;
         m.m_addr  <= '0;
         m.m_wdata <= '0;
      end else if (load_ok) begin
         m.m_valid <= (gnt != GNT_NONE);
         if (gnt == GNT_WR) begin
            m.m_we    <= 1'b1;
            m.m_addr  <= wr_addr;
            m.m_wdata <= wr_data;
         end else if (gnt == GNT_RD) begin
            m.m_we    <= 1'b0;
            m.m_addr  <= rd_addr;
         end
      end
   end

   // The streak only measures reads taken while a write is actually waiting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak <= 8'd0;
      end else if (!wr_valid || gnt == GNT_WR) begin
         streak <= 8'd0;
      end else if (gnt == GNT_RD && !streak_sat) begin
         streak <= streak + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy <= 1'b0;
      end else begin
         busy <= m_valid_nxt || active_nxt;
      end
   end

   sram_rd_tracker #(
      .DATA_W          (DATA_W),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
   ) u_rd_tracker (
      .clk          (clk),
      .rst          (rst),
      .fire_rd      (fire_rd),
      .pending_rd   (pending_rd),
      .rsp_valid    (m.m_rsp_valid),
      .rsp_data     (m.m_rsp_data),
      .rd_full      (rd_full),
      .active_nxt   (active_nxt),
      .rd_rsp_valid (rd_rsp_valid),
      .rd_rsp_data  (rd_rsp_data)
   );

`ifdef SRAM_ARB_STATS_EN
   // Starvation grants are writes that only won because the read streak saturated.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_rd_cnt     <= 32'd0;
         stat_wr_cnt     <= 32'd0;
         stat_starve_cnt <= 16'd0;
      end else begin
         if (m.m_valid && m.m_ready && !m.m_we) begin
            stat_rd_cnt <= stat_rd_cnt + 32'd1;
         end
         if (m.m_valid && m.m_ready && m.m_we) begin
            stat_wr_cnt <= stat_wr_cnt + 32'd1;
         end
         if (gnt == GNT_WR && streak_sat && rd_elig) begin
            stat_starve_cnt <= stat_starve_cnt + 16'd1;
         end
      end
   end
`endif

endmodule
